// File: rtl/cache_lru_pkg.sv
// Recency-order types and move-to-front/back helpers, sized for up to 8 ways; no state.
// Purely combinational helpers; callers pass the real way count so slots beyond it are ignored.
package cache_lru_pkg;

  localparam int MAX_WAYS  = 8;
  localparam int MAX_IDX_W = 3;

  typedef logic [MAX_IDX_W-1:0] way_t;
  typedef way_t [MAX_WAYS-1:0]  order_t;   // slot 0 = MRU

  typedef enum logic {S_INIT, S_RUN} state_t;

  function automatic order_t identity_order();
    order_t r;
    for (int k = 0; k < MAX_WAYS; k++) r[k] = way_t'(k);
    return r;
  endfunction

  // Entries ahead of the touched way slide one slot toward LRU; the rest stay put.
  function automatic order_t move_to_front(input order_t o, input way_t way);
    order_t r;
    logic   seen;
    r    = o;
    seen = 1'b0;
    r[0] = way;
    for (int k = 1; k < MAX_WAYS; k++) begin
      if (o[k-1] == way) seen = 1'b1;
      r[k] = seen ? o[k] : o[k-1];
    end
    return r;
  endfunction

  function automatic order_t move_to_back(input order_t o, input way_t way, input int ways);
    order_t r;
    logic   seen;
    r    = o;
    seen = 1'b0;
    for (int k = 0; k < MAX_WAYS - 1; k++) begin
      if (o[k] == way) seen = 1'b1;
      if (k < ways - 1) r[k] = seen ? o[k+1] : o[k];
    end
    for (int k = 0; k < MAX_WAYS; k++) begin
      if (k == ways - 1) r[k] = way;
    end
    return r;
  endfunction

endpackage

// File: rtl/lru_order_ram.sv
// Simple dual-port order RAM, registered read; a same-cycle write to the read address is
// forwarded so the next-cycle read data is the new word. One access per port per cycle, no stalls.
module lru_order_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          main_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] byp_dat;
  logic          byp_q;

  always_ff @(posedge main_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q    <= mem[rd_addr];
    byp_q   <= wr_en && (wr_addr == rd_addr);
    byp_dat <= wr_data;
  end

  assign rd_data = byp_q ? byp_dat : rd_q;

endmodule

// File: rtl/cache_lru_gen.sv
// Per-set LRU tracker: victim of the set presented last cycle, touch/invalidate applied one cycle later.
// Full rate in RUN with no backpressure; all ops ignored while the post-reset init sweep runs.
module cache_lru_gen
  import cache_lru_pkg::*;
#(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 11,
  parameter int IDX_W    = $clog2(WAYS)
) (
  input  logic                main_clk,
  input  logic                rst,
  input  logic [SET_BITS-1:0] addr,
  input  logic [IDX_W-1:0]    used_index,
  input  logic                enable_write,
  input  logic                invalidate,
  output logic [IDX_W-1:0]    least_used_index,
  output logic                init_busy
);

  localparam int WORD_W = WAYS * IDX_W;

  state_t              state_q, state_d;
  logic [SET_BITS-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [SET_BITS-1:0] write_addr;
  logic [IDX_W-1:0]    used_q;
  logic                touch_q, inval_q;

  logic                ram_we;
  logic [SET_BITS-1:0] ram_waddr;
  logic [WORD_W-1:0]   ram_wdata, ram_rdata;

  order_t rd_order, upd_order, ident;
  logic   unused_bits;

  always_ff @(posedge main_clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      sweep_cnt_q <= '0;
      touch_q     <= 1'b0;
      inval_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      touch_q     <= (state_q == S_RUN) && enable_write;
      inval_q     <= (state_q == S_RUN) && invalidate && !enable_write;
    end
  end

  always_ff @(posedge main_clk) begin
    write_addr <= addr;
    used_q     <= used_index;
  end

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    init_busy   = 1'b0;
    case (state_q)
      S_INIT: begin
        init_busy   = 1'b1;
        sweep_cnt_d = sweep_cnt_q + 1'b1;
        if (&sweep_cnt_q) state_d = S_RUN;
      end
      S_RUN: ;
    endcase
  end

  always_comb begin
    rd_order = '0;
    for (int k = 0; k < WAYS; k++) rd_order[k] = way_t'(ram_rdata[k*IDX_W +: IDX_W]);
  end

  assign ident       = identity_order();
  assign upd_order   = touch_q ? move_to_front(rd_order, way_t'(used_q))
                               : move_to_back(rd_order, way_t'(used_q), WAYS);
  assign unused_bits = ^{upd_order, ident};

  // Sweep owns the write port during INIT; a reset cycle drops any pending update.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = write_addr;
    ram_wdata = '0;
    if (state_q == S_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_cnt_q;
      for (int k = 0; k < WAYS; k++) ram_wdata[k*IDX_W +: IDX_W] = ident[k][IDX_W-1:0];
    end else begin
      ram_we = (touch_q || inval_q) && !rst;
      for (int k = 0; k < WAYS; k++) ram_wdata[k*IDX_W +: IDX_W] = upd_order[k][IDX_W-1:0];
    end
  end

  lru_order_ram #(
    .DW (WORD_W),
    .AW (SET_BITS)
  ) u_ram (
    .main_clk (main_clk),
    .wr_en    (ram_we),
    .wr_addr  (ram_waddr),
    .wr_data  (ram_wdata),
    .rd_addr  (addr),
    .rd_data  (ram_rdata)
  );

  assign least_used_index = init_busy ? IDX_W'(WAYS - 1) : rd_order[WAYS-1][IDX_W-1:0];

endmodule

// File: tb/tb_cache_lru_gen.sv
// Self-checking bench for cache_lru_gen: directed vector table on a 4-way instance,
// reset/sweep sequences, and a random soak of 2-way and 8-way instances against a reference model.
module tb_cache_lru_gen;

  logic       main_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] addr = '0;
  logic [1:0] used_index = '0;
  logic       enable_write = 1'b0;
  logic       invalidate = 1'b0;
  logic [1:0] least_used_index;
  logic       init_busy;

  logic [3:0] s_addr = '0;
  logic [0:0] s_idx2 = '0;
  logic [2:0] s_idx8 = '0;
  logic       s_ew2 = 1'b0, s_inv2 = 1'b0, s_ew8 = 1'b0, s_inv8 = 1'b0;
  logic [0:0] lui2;
  logic [2:0] lui8;
  logic       busy2, busy8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 main_clk = ~main_clk;

  cache_lru_gen #(.WAYS(4), .SET_BITS(4)) dut4 (
    .main_clk(main_clk), .rst(rst), .addr(addr), .used_index(used_index),
    .enable_write(enable_write), .invalidate(invalidate),
    .least_used_index(least_used_index), .init_busy(init_busy));

  cache_lru_gen #(.WAYS(2), .SET_BITS(4)) dut2 (
    .main_clk(main_clk), .rst(rst), .addr(s_addr), .used_index(s_idx2),
    .enable_write(s_ew2), .invalidate(s_inv2),
    .least_used_index(lui2), .init_busy(busy2));

  cache_lru_gen #(.WAYS(8), .SET_BITS(4)) dut8 (
    .main_clk(main_clk), .rst(rst), .addr(s_addr), .used_index(s_idx8),
    .enable_write(s_ew8), .invalidate(s_inv8),
    .least_used_index(lui8), .init_busy(busy8));

  typedef struct {
    logic [3:0] a;
    int         idx;
    logic       ew;
    logic       inv;
    logic       chk;
    int         exp;
  } vec_t;

  typedef struct {
    int    exp;
    string nm;
  } sb_t;

  typedef logic [7:0][2:0] mord_t;

  vec_t  vt[$];
  sb_t   q4[$];
  int    q2[$];
  int    q8[$];
  mord_t m2[16];
  mord_t m8[16];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input int a, input int idx, input logic ew, input logic inv,
                              input logic chk, input int exp);
    vec_t v;
    v.a = 4'(a); v.idx = idx; v.ew = ew; v.inv = inv; v.chk = chk; v.exp = exp;
    vt.push_back(v);
  endfunction

  task automatic step4(input logic [3:0] a, input int idx, input logic ew, input logic inv,
                       input logic chk, input int exp, input string nm);
    sb_t e;
    addr = a; used_index = 2'(idx); enable_write = ew; invalidate = inv;
    if (chk) begin
      e.exp = exp; e.nm = nm;
      q4.push_back(e);
    end
    @(posedge main_clk); #1;
    if (chk) begin
      e = q4.pop_front();
      check(e.nm, int'(least_used_index), e.exp);
    end
  endtask

  // Counts init_busy cycles from the current (sweep cycle 0) point onward.
  task automatic count_busy(input string nm, input logic strobe);
    int   n;
    logic bad;
    n = 0; bad = 1'b0;
    while (init_busy && n < 100) begin
      if (least_used_index != 2'd3) bad = 1'b1;
      if (strobe) begin
        enable_write = 1'b1; invalidate = n[0]; addr = 4'd5; used_index = 2'(n);
      end
      n++;
      @(posedge main_clk); #1;
    end
    enable_write = 1'b0; invalidate = 1'b0;
    check(nm, n, 16);
    check({nm, "_victim"}, int'(bad), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge main_clk); #1;
    rst = 1'b0;
  endtask

  function automatic mord_t m_touch(input mord_t o, input int w, input int ways);
    mord_t r;
    int    j;
    r = '0; r[0] = 3'(w); j = 1;
    for (int k = 0; k < ways; k++)
      if (int'(o[k]) != w) begin r[j] = o[k]; j++; end
    return r;
  endfunction

  function automatic mord_t m_inval(input mord_t o, input int w, input int ways);
    mord_t r;
    int    j;
    r = '0; j = 0;
    for (int k = 0; k < ways; k++)
      if (int'(o[k]) != w) begin r[j] = o[k]; j++; end
    r[ways-1] = 3'(w);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion within time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0]  a;
    logic [1:0]  r2, r8;
    int          i2, i8;
    logic [23:0] w8;
    logic [1:0]  w2;

    // Reset state of all three instances
    @(posedge main_clk); #1;
    check("rst_busy4", int'(init_busy), 1);
    check("rst_victim4", int'(least_used_index), 3);
    check("rst_busy8", int'(busy8), 1);
    check("rst_victim8", int'(lui8), 7);
    check("rst_victim2", int'(lui2), 1);
    rst = 1'b0;
    count_busy("sweep_len", 1'b0);
    check("run_busy8", int'(busy8), 0);

    // Directed table on the 4-way instance
    for (int s = 0; s < 16; s++) add(s, 0, 0, 0, 1, 3);
    add(5, 3, 1, 0, 1, 3); add(0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0); add(5, 0, 0, 0, 1, 2);
    add(5, 2, 1, 0, 1, 2); add(5, 1, 1, 0, 1, 1); add(5, 0, 0, 0, 1, 0);
    add(9, 3, 1, 0, 1, 3); add(9, 2, 1, 0, 1, 2); add(9, 1, 1, 0, 1, 1); add(9, 0, 0, 0, 1, 0);
    add(7, 0, 1, 0, 1, 3); add(7, 1, 1, 0, 1, 3); add(7, 2, 1, 0, 1, 3); add(7, 3, 1, 0, 1, 3);
    add(7, 2, 0, 1, 1, 0); add(7, 1, 1, 1, 1, 2); add(7, 0, 0, 0, 1, 2);
    add(7, 2, 0, 1, 1, 2); add(7, 1, 0, 1, 1, 2); add(7, 0, 0, 0, 1, 1);
    add(7, 3, 1, 0, 1, 1); add(7, 0, 0, 0, 1, 1);
    add(5, 0, 0, 0, 1, 0); add(9, 0, 0, 0, 1, 0); add(6, 0, 0, 0, 1, 3);
    for (int i = 0; i < vt.size(); i++)
      step4(vt[i].a, vt[i].idx, vt[i].ew, vt[i].inv, vt[i].chk, vt[i].exp, $sformatf("vec%0d", i));

    // Strobes during sweep are ignored and set 5 loses its old order
    pulse_rst();
    count_busy("sweep_strobed", 1'b1);
    step4(4'd5, 0, 0, 0, 1, 3, "set5_cleared");
    step4(4'd9, 0, 0, 0, 1, 3, "set9_cleared");
    step4(4'd5, 3, 1, 0, 1, 3, "post_init_touch");
    step4(4'd5, 0, 0, 0, 1, 2, "post_init_victim");

    // Reset at sweep cycle 9 restarts the full sweep
    pulse_rst();
    for (int i = 0; i < 9; i++) begin
      @(posedge main_clk); #1;
    end
    check("mid_sweep_busy", int'(init_busy), 1);
    pulse_rst();
    count_busy("sweep_restart", 1'b0);

    // Random soak on 2-way and 8-way instances
    for (int s = 0; s < 16; s++)
      for (int k = 0; k < 8; k++) begin
        m2[s][k] = 3'(k);
        m8[s][k] = 3'(k);
      end
    for (int i = 0; i < 1500; i++) begin
      a  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      r2 = 2'($urandom_range(0, 3));
      r8 = 2'($urandom_range(0, 3));
      i2 = $urandom_range(0, 1);
      i8 = $urandom_range(0, 7);
      s_addr = a; s_idx2 = 1'(i2); s_idx8 = 3'(i8);
      s_ew2 = r2[0]; s_inv2 = r2[1]; s_ew8 = r8[0]; s_inv8 = r8[1];
      q2.push_back(int'(m2[a][1]));
      q8.push_back(int'(m8[a][7]));
      if (r2[0]) m2[a] = m_touch(m2[a], i2, 2);
      else if (r2[1]) m2[a] = m_inval(m2[a], i2, 2);
      if (r8[0]) m8[a] = m_touch(m8[a], i8, 8);
      else if (r8[1]) m8[a] = m_inval(m8[a], i8, 8);
      @(posedge main_clk); #1;
      check($sformatf("soak2_%0d", i), int'(lui2), q2.pop_front());
      check($sformatf("soak8_%0d", i), int'(lui8), q8.pop_front());
    end
    s_ew2 = 1'b0; s_inv2 = 1'b0; s_ew8 = 1'b0; s_inv8 = 1'b0;
    repeat (2) begin
      @(posedge main_clk); #1;
    end

    // Stored words must equal the reference permutation of each set
    for (int s = 0; s < 16; s++) begin
      w8 = '0; w2 = '0;
      for (int k = 0; k < 8; k++) w8[k*3 +: 3] = m8[s][k];
      for (int k = 0; k < 2; k++) w2[k] = m2[s][k][0];
      check($sformatf("word8_set%0d", s), int'(dut8.u_ram.mem[s]), int'(w8));
      check($sformatf("word2_set%0d", s), int'(dut2.u_ram.mem[s]), int'(w2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_lru_gen.md
# cache_lru_gen

Parametrised LRU replacement tracker for the set-associative caches in front of the DRAM controller. For each set it holds a full recency order of `WAYS` ways, returns the least-recently-used way one cycle after a set address is presented, and applies touch (move-to-MRU) or invalidate (move-to-LRU) updates with read-through-write forwarding. This generalises the fixed 4-way permutation tracker. It adds a way count parameter, an explicit invalidate operation and a self-initialising reset sweep.

## Interface
- `WAYS`, 4, number of ways; power of two, 2..8
- `SET_BITS`, 11, set address width; depth = 2^SET_BITS
- `IDX_W`, $clog2(WAYS), derived; not to be overridden
- `main_clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  SET_BITS  set being looked up this cycle
- `used_index`  in  IDX_W  way operand for touch/invalidate
- `enable_write`  in  1  touch: `used_index` becomes MRU of set `addr`
- `invalidate`  in  1  `used_index` becomes LRU of set `addr`
- `least_used_index`  out  IDX_W  victim way of set presented previous cycle
- `init_busy`  out  1  high while reset sweep runs; ops ignored

## Operation
- Per-set word: ordered list of `WAYS` way indices, slot 0 = MRU, slot `WAYS-1` = LRU; `WAYS*IDX_W` bits. It is always a permutation.
- Identity order (slot k holds way k) is the initial value of every set. The initial victim is `WAYS-1`.
- Touch: remove `used_index` from the list, shift the more-recent entries down one slot, insert it at slot 0. Touching the current MRU leaves the word unchanged.
- Invalidate: remove `used_index` and insert it at slot `WAYS-1`. Invalidating the current LRU leaves the word unchanged.
- `enable_write` and `invalidate` both high: the touch is performed and the invalidate is dropped.
- `used_index` is don't-care when neither strobe is high.
- State machine, two states:
  - INIT, entered on `rst`: counter walks sets 0..2^SET_BITS-1, writing the identity order, one set per cycle. `init_busy`=1. Strobes are ignored. `least_used_index` is forced to `WAYS-1`.
  - RUN: entered the cycle after the last set is written. `init_busy` falls in the same cycle.
- `rst` asserted mid-sweep restarts the counter at 0. `rst` asserted in RUN discards any in-flight update.

## Timing
- Reset values: `init_busy`=1 and `least_used_index`=`WAYS-1` in the cycle after `rst` is sampled. Sweep length is exactly 2^SET_BITS cycles.
- Lookup latency: `addr` presented in cycle N gives `least_used_index` valid in cycle N+1. That output is combinational from the RAM registered read plus the bypass mux; it is not registered again.
- Update pipeline:
  - Strobe, `used_index` and `addr` are sampled in cycle N.
  - The new order is computed in N+1 from the N+1 read data.
  - The new order is written at the end of N+1.
- Read-through-write: if a read address equals the write address in the same cycle, the next-cycle read data is the value being written, not the RAM output.
  - Consequence: back-to-back updates to one set in N and N+1 chain correctly.
  - Consequence: a lookup in N+1 of a set updated in N returns the post-update victim in N+2.
- Full throughput: one lookup/update per cycle in RUN, no stalls, no backpressure.

## Structure
- Package `cache_lru_pkg`: `order_t` helpers parametrised by `WAYS`, `move_to_front`/`move_to_back` functions, identity-order constant function.
- Sub-module `lru_order_ram`: simple dual-port RAM, registered read, unspecified read-during-write. It includes its own address-compare bypass register, so the top sees forwarded data only.
- Top holds:
  - the INIT/RUN FSM and sweep counter;
  - the one-stage delay registers (`write_addr`, strobes, `used_index`);
  - the update logic and write-port mux between sweep and update.

## Test plan
All scenarios run with `WAYS`=4, `SET_BITS`=4.
- Reset sweep: `rst` pulse → `init_busy` high 16 cycles, then a lookup of each set 0..15 returns 3.
- Single touch: touch way 3 on set 5, wait 2 cycles, look up set 5 → 2. Touch 2, then 1 → victim 0.
- Back-to-back chaining: touches of ways 3, 2, 1 on set 5 in consecutive cycles, lookup of set 5 in the following cycle → 0, with no stale value.
- Invalidate and precedence:
  - Touch 0, 1, 2, 3 on set 7, then invalidate 2 → victim 2.
  - Touch 1 and invalidate 1 in the same cycle → 1 becomes MRU, victim stays 2.
- Init and reset behaviour:
  - Strobes asserted during sweep have no effect.
  - `rst` at sweep cycle 9 → sweep restarts and `init_busy` lasts 16 further cycles.
  - Set 5 retains no prior order.
- Random soak with WAYS ∈ {2, 8}: random addr/strobes versus a behavioural reference model; every `least_used_index` matches and every stored word remains a permutation.
